// File: rtl/lampboard_sequencer.sv
// Queues keypresses, handshakes each one with the cipher core, shows the plain/cipher pair on new-frame edges.
// Key to enc_req_out is 2 cycles; key_ready_out falls when the queue is full and excess keys are counted as drops.
module lampboard_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 30,
  parameter int ENC_TIMEOUT = 255
) (
  input  logic       clk_pixel,
  input  logic       sys_rst_pixel,
  input  logic       key_valid_in,
  input  logic [4:0] key_letter_in,
  output logic       key_ready_out,
  output logic       enc_req_out,
  output logic [4:0] enc_letter_out,
  input  logic       enc_ack_in,
  input  logic [4:0] enc_letter_in,
  input  logic       nf_in,
  output logic [4:0] orig_letter_out,
  output logic [4:0] code_letter_out,
  output logic       busy_out,
  output logic [7:0] drop_count_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, ARM, HOLD} state_t;
  state_t state, state_nxt;

  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [4:0]    key_reg, code_reg;
  logic [7:0]    hold_cnt;
  logic [9:0]    tmo_cnt;

  logic key_ok, pop, push, drop, tmo_hit;

  assign key_ok  = key_valid_in && (key_letter_in != 5'd0) && (key_letter_in <= 5'd26);
  assign pop     = (state == IDLE) && (count != '0);
  // A full queue still accepts a key when the head leaves in the same cycle.
  assign push    = key_ok && ((count < CW'(FIFO_DEPTH)) || pop);
  assign drop    = key_ok && !push;
  assign tmo_hit = (tmo_cnt == 10'(ENC_TIMEOUT - 1));

  assign key_ready_out = (count < CW'(FIFO_DEPTH));

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    enc_req_out    = 1'b0;
    enc_letter_out = 5'd0;
    busy_out       = (state != IDLE);
    unique case (state)
      IDLE: if (pop) state_nxt = REQ;
      REQ: begin
        enc_req_out    = 1'b1;
        enc_letter_out = key_reg;
        if (enc_ack_in || tmo_hit) state_nxt = ARM;
      end
      ARM:  if (nf_in) state_nxt = HOLD;
      HOLD: if (nf_in && (hold_cnt == 8'd1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_pixel) begin
    if (push) fifo_mem[wr_ptr] <= key_letter_in;
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      key_reg         <= 5'd0;
      code_reg        <= 5'd0;
      hold_cnt        <= 8'd0;
      tmo_cnt         <= 10'd0;
      orig_letter_out <= 5'd0;
      code_letter_out <= 5'd0;
      drop_count_out  <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        key_reg <= fifo_mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
        tmo_cnt <= 10'd0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (drop && (drop_count_out != 8'hFF)) drop_count_out <= drop_count_out + 8'd1;

      if (state == REQ) begin
        if (enc_ack_in)   code_reg <= enc_letter_in;
        else if (tmo_hit) code_reg <= 5'd0;
        else              tmo_cnt  <= tmo_cnt + 10'd1;
      end

      if ((state == ARM) && nf_in) begin
        orig_letter_out <= key_reg;
        code_letter_out <= code_reg;
        hold_cnt        <= 8'(HOLD_FRAMES);
      end

      if ((state == HOLD) && nf_in) begin
        if (hold_cnt == 8'd1) begin
          orig_letter_out <= 5'd0;
          code_letter_out <= 5'd0;
          hold_cnt        <= 8'd0;
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lampboard_sequencer.sv
// Directed bench for lampboard_sequencer with default parameters (depth 4, 30 frames, 255-cycle timeout).
module tb_lampboard_sequencer;

  logic       clk_pixel = 1'b0;
  logic       sys_rst_pixel;
  logic       key_valid_in;
  logic [4:0] key_letter_in;
  logic       key_ready_out;
  logic       enc_req_out;
  logic [4:0] enc_letter_out;
  logic       enc_ack_in;
  logic [4:0] enc_letter_in;
  logic       nf_in;
  logic [4:0] orig_letter_out;
  logic [4:0] code_letter_out;
  logic       busy_out;
  logic [7:0] drop_count_out;

  int total = 0;
  int bad   = 0;

  lampboard_sequencer dut (
    .clk_pixel       (clk_pixel),
    .sys_rst_pixel   (sys_rst_pixel),
    .key_valid_in    (key_valid_in),
    .key_letter_in   (key_letter_in),
    .key_ready_out   (key_ready_out),
    .enc_req_out     (enc_req_out),
    .enc_letter_out  (enc_letter_out),
    .enc_ack_in      (enc_ack_in),
    .enc_letter_in   (enc_letter_in),
    .nf_in           (nf_in),
    .orig_letter_out (orig_letter_out),
    .code_letter_out (code_letter_out),
    .busy_out        (busy_out),
    .drop_count_out  (drop_count_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_pixel = 1'b1;
    key_valid_in  = 1'b0;
    key_letter_in = 5'd0;
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
    nf_in         = 1'b0;
    step();
    sys_rst_pixel = 1'b0;
  endtask

  task automatic press(input logic [4:0] l);
    key_valid_in  = 1'b1;
    key_letter_in = l;
    step();
    key_valid_in  = 1'b0;
    key_letter_in = 5'd0;
  endtask

  task automatic nf_pulse();
    nf_in = 1'b1;
    step();
    nf_in = 1'b0;
    step();
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (enc_req_out) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Acts as the cipher core for one request: check the presented letter, ack with code.
  task automatic serve(input logic [4:0] want, input logic [4:0] code);
    bit seen;
    wait_req(seen);
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL serve_req: enc_req_out never rose (want letter %0d)", want);
    end
    total++;
    if (enc_letter_out !== want) begin
      bad++;
      $display("FAIL serve_letter: got %0d want %0d", enc_letter_out, want);
    end
    enc_ack_in    = 1'b1;
    enc_letter_in = code;
    step();
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (key_ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %0b want 1", key_ready_out);
    end
    total++;
    if ({enc_req_out, enc_letter_out, busy_out} !== 7'd0) begin
      bad++; $display("FAIL reset_req: req=%0b letter=%0d busy=%0b want all 0", enc_req_out, enc_letter_out, busy_out);
    end
    total++;
    if ({orig_letter_out, code_letter_out, drop_count_out} !== 18'd0) begin
      bad++; $display("FAIL reset_disp: orig=%0d code=%0d drops=%0d want all 0", orig_letter_out, code_letter_out, drop_count_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    press(5'd5);
    total++;
    if (enc_req_out !== 1'b0) begin
      bad++; $display("FAIL basic_cyc1_req: got %0b want 0", enc_req_out);
    end
    step();
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (enc_req_out !== 1'b1 || enc_letter_out !== 5'd5) begin
        bad++; $display("FAIL basic_req_cyc%0d: req=%0b letter=%0d want 1/5", c, enc_req_out, enc_letter_out);
      end
      if (c == 4) begin
        enc_ack_in    = 1'b1;
        enc_letter_in = 5'd17;
      end
      step();
    end
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
    total++;
    if (enc_req_out !== 1'b0 || enc_letter_out !== 5'd0 || orig_letter_out !== 5'd0) begin
      bad++; $display("FAIL basic_after_ack: req=%0b letter=%0d orig=%0d want 0/0/0", enc_req_out, enc_letter_out, orig_letter_out);
    end
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd5 || code_letter_out !== 5'd17) begin
      bad++; $display("FAIL basic_display: orig=%0d code=%0d want 5/17", orig_letter_out, code_letter_out);
    end
    for (int f = 0; f < 29; f++) nf_pulse();
    total++;
    if (orig_letter_out !== 5'd5 || code_letter_out !== 5'd17 || busy_out !== 1'b1) begin
      bad++; $display("FAIL basic_hold29: orig=%0d code=%0d busy=%0b want 5/17/1", orig_letter_out, code_letter_out, busy_out);
    end
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd0 || code_letter_out !== 5'd0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL basic_blank: orig=%0d code=%0d busy=%0b want 0/0/0", orig_letter_out, code_letter_out, busy_out);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    do_reset();
    press(5'd9);
    wait_req(seen);
    n = 0;
    while (enc_req_out && n < 400) begin
      n++;
      step();
    end
    total++;
    if (seen !== 1'b1 || n != 255) begin
      bad++; $display("FAIL timeout_len: req seen=%0b high for %0d cycles want 255", seen, n);
    end
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd9 || code_letter_out !== 5'd0) begin
      bad++; $display("FAIL timeout_display: orig=%0d code=%0d want 9/0", orig_letter_out, code_letter_out);
    end
    for (int f = 0; f < 30; f++) nf_pulse();
    total++;
    if (busy_out !== 1'b0 || orig_letter_out !== 5'd0) begin
      bad++; $display("FAIL timeout_idle: busy=%0b orig=%0d want 0/0", busy_out, orig_letter_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] keys [6];
    keys = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd26};
    do_reset();
    press(5'd3);
    serve(5'd3, 5'd11);
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd3 || code_letter_out !== 5'd11) begin
      bad++; $display("FAIL b2b_first: orig=%0d code=%0d want 3/11", orig_letter_out, code_letter_out);
    end
    for (int i = 0; i < 6; i++) begin
      key_valid_in  = 1'b1;
      key_letter_in = keys[i];
      step();
      if (i == 2) begin
        total++;
        if (key_ready_out !== 1'b1) begin
          bad++; $display("FAIL b2b_ready3: got %0b want 1", key_ready_out);
        end
      end
      if (i == 3) begin
        total++;
        if (key_ready_out !== 1'b0) begin
          bad++; $display("FAIL b2b_ready4: got %0b want 0", key_ready_out);
        end
      end
    end
    key_valid_in  = 1'b0;
    key_letter_in = 5'd0;
    total++;
    if (drop_count_out !== 8'd2) begin
      bad++; $display("FAIL b2b_drops: got %0d want 2", drop_count_out);
    end
    for (int f = 0; f < 30; f++) nf_pulse();
    total++;
    if (orig_letter_out !== 5'd0 || key_ready_out !== 1'b1) begin
      bad++; $display("FAIL b2b_gap0: orig=%0d ready=%0b want 0/1", orig_letter_out, key_ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      serve(keys[i], keys[i] + 5'd1);
      nf_pulse();
      total++;
      if (orig_letter_out !== keys[i] || code_letter_out !== keys[i] + 5'd1) begin
        bad++; $display("FAIL b2b_show%0d: orig=%0d code=%0d want %0d/%0d", i, orig_letter_out, code_letter_out, keys[i], keys[i] + 5'd1);
      end
      for (int f = 0; f < 30; f++) nf_pulse();
      total++;
      if (orig_letter_out !== 5'd0 || code_letter_out !== 5'd0) begin
        bad++; $display("FAIL b2b_blank%0d: orig=%0d code=%0d want 0/0", i, orig_letter_out, code_letter_out);
      end
    end
    step();
    total++;
    if (busy_out !== 1'b0 || drop_count_out !== 8'd2) begin
      bad++; $display("FAIL b2b_end: busy=%0b drops=%0d want 0/2", busy_out, drop_count_out);
    end
  endtask

  // Runs straight after test_back_to_back so the drop count starts at 2.
  task automatic test_bad_letters();
    press(5'd0);
    press(5'd27);
    press(5'd31);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (enc_req_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL badkey_req: req=%0b busy=%0b want 0/0", enc_req_out, busy_out);
    end
    total++;
    if (drop_count_out !== 8'd2 || key_ready_out !== 1'b1) begin
      bad++; $display("FAIL badkey_drops: drops=%0d ready=%0b want 2/1", drop_count_out, key_ready_out);
    end
  endtask

  task automatic test_nf_with_ack();
    bit seen;
    do_reset();
    press(5'd7);
    wait_req(seen);
    enc_ack_in    = 1'b1;
    enc_letter_in = 5'd20;
    nf_in         = 1'b1;
    step();
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
    nf_in         = 1'b0;
    total++;
    if (seen !== 1'b1 || orig_letter_out !== 5'd0 || busy_out !== 1'b1) begin
      bad++; $display("FAIL nfack_early: seen=%0b orig=%0d busy=%0b want 1/0/1", seen, orig_letter_out, busy_out);
    end
    for (int i = 0; i < 3; i++) step();
    total++;
    if (orig_letter_out !== 5'd0 || code_letter_out !== 5'd0) begin
      bad++; $display("FAIL nfack_wait: orig=%0d code=%0d want 0/0", orig_letter_out, code_letter_out);
    end
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd7 || code_letter_out !== 5'd20) begin
      bad++; $display("FAIL nfack_show: orig=%0d code=%0d want 7/20", orig_letter_out, code_letter_out);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    press(5'd12);
    wait_req(seen);
    sys_rst_pixel = 1'b1;
    step();
    sys_rst_pixel = 1'b0;
    total++;
    if (seen !== 1'b1 || enc_req_out !== 1'b0 || enc_letter_out !== 5'd0 || busy_out !== 1'b0 || key_ready_out !== 1'b1) begin
      bad++; $display("FAIL rstreq_outs: seen=%0b req=%0b letter=%0d busy=%0b ready=%0b want 1/0/0/0/1", seen, enc_req_out, enc_letter_out, busy_out, key_ready_out);
    end
    enc_ack_in    = 1'b1;
    enc_letter_in = 5'd5;
    step();
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
    nf_pulse();
    total++;
    if (busy_out !== 1'b0 || orig_letter_out !== 5'd0 || code_letter_out !== 5'd0) begin
      bad++; $display("FAIL rstreq_lateack: busy=%0b orig=%0d code=%0d want 0/0/0", busy_out, orig_letter_out, code_letter_out);
    end

    press(5'd14);
    serve(5'd14, 5'd15);
    nf_pulse();
    press(5'd2);
    total++;
    if (orig_letter_out !== 5'd14 || code_letter_out !== 5'd15) begin
      bad++; $display("FAIL rsthold_pre: orig=%0d code=%0d want 14/15", orig_letter_out, code_letter_out);
    end
    sys_rst_pixel = 1'b1;
    step();
    sys_rst_pixel = 1'b0;
    total++;
    if (orig_letter_out !== 5'd0 || code_letter_out !== 5'd0 || busy_out !== 1'b0 || key_ready_out !== 1'b1) begin
      bad++; $display("FAIL rsthold_outs: orig=%0d code=%0d busy=%0b ready=%0b want 0/0/0/1", orig_letter_out, code_letter_out, busy_out, key_ready_out);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (enc_req_out !== 1'b0 || busy_out !== 1'b0) begin
      bad++; $display("FAIL rsthold_fifo: req=%0b busy=%0b want 0/0 (queued key must be gone)", enc_req_out, busy_out);
    end

    press(5'd19);
    serve(5'd19, 5'd21);
    nf_pulse();
    total++;
    if (orig_letter_out !== 5'd19 || code_letter_out !== 5'd21) begin
      bad++; $display("FAIL rst_recover: orig=%0d code=%0d want 19/21", orig_letter_out, code_letter_out);
    end
  endtask

  initial begin
    sys_rst_pixel = 1'b1;
    key_valid_in  = 1'b0;
    key_letter_in = 5'd0;
    enc_ack_in    = 1'b0;
    enc_letter_in = 5'd0;
    nf_in         = 1'b0;
    step();
    step();
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_bad_letters();
    test_nf_with_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
